// File: rtl/data_mem_lsu.sv
// -----------------------------------------------------------------------------
// data_mem_lsu
// -----------------------------------------------------------------------------
// Purpose
//   Load/store unit on the initiator side of a word-addressed data memory.
//   Accepts byte-addressed RV32 loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW)
//   and turns each one into word accesses. The memory can only write whole
//   words, so SB/SH are done as read-modify-write. Load results are pulled out
//   of the read word and sign- or zero-extended.
//
// Ports
//   clk         in   1   clock, rising edge
//   reset       in   1   asynchronous, active-high reset
//   req_valid   in   1   core request valid
//   req_ready   out  1   LSU can accept (high only in IDLE)
//   req_we      in   1   1 = store, 0 = load
//   req_funct3  in   3   RV32 funct3 (access size / sign)
//   req_addr    in   32  byte address
//   req_wdata   in   32  store data, right-aligned
//   resp_valid  out  1   one-cycle pulse, request complete
//   resp_rdata  out  32  extended load result (0 for stores and errors)
//   resp_err    out  1   misaligned / illegal / out-of-range, qualified by resp_valid
//   mem_addr    out  32  word index to memory = {2'b00, addr[31:2]}
//   mem_wdata   out  32  write word to memory
//   mem_we      out  1   memory write enable
//   mem_rdata   in   32  memory read data, valid the cycle after mem_addr
//
// Configuration
//   LSU_BOUNDS_CHECK_EN  when defined, a word index addr[31:2] >= MEM_WORDS is
//                        reported as an error and never reaches the memory.
//                        When undefined the full word index is passed through.
//
// Timing (N = acceptance edge, counted in cycles after N)
//   error: resp at cycle 1   (ERR)
//   SW   : resp at cycle 2   (WR, RESP)
//   load : resp at cycle 3   (RD, MRG, RESP)
//   SB/SH: resp at cycle 4   (RD, MRG, WR, RESP)
// -----------------------------------------------------------------------------
module data_mem_lsu #(
   parameter int MEM_WORDS = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_we,
   input  logic [31:0] mem_rdata
);

   // A memory of zero words makes the range check meaningless.
   if (MEM_WORDS < 1) begin : g_bad_depth
      $error("data_mem_lsu: MEM_WORDS must be at least 1");
   end

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD   = 3'd1,
      MRG  = 3'd2,
      WR   = 3'd3,
      RESP = 3'd4,
      ERR  = 3'd5
   } state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   state_t      state_reg;

   // Only the fields still needed after acceptance are kept: the word index
   // goes straight into mem_addr, and SB/SH only ever use the low halfword.
   logic        we_reg;
   logic [2:0]  funct3_reg;
   logic [1:0]  offset_reg;
   logic [15:0] wdata_reg;

   // -------------------------------------------------------------------------
   // Request decode (evaluated on the raw request while in IDLE)
   // -------------------------------------------------------------------------
   logic        funct3_legal;
   logic        misaligned;
   logic        out_of_range;
   logic        req_err_next;
   logic        req_is_sw;
   logic [31:0] word_index;

   assign word_index = {2'b00, req_addr[31:2]};

`ifdef LSU_BOUNDS_CHECK_EN
   assign out_of_range = (word_index >= 32'(MEM_WORDS));
`else
   assign out_of_range = 1'b0;
`endif

   always_comb begin
      funct3_legal = 1'b0;
      if (req_we) begin
         funct3_legal = (req_funct3 == F3_B) || (req_funct3 == F3_H) ||
                        (req_funct3 == F3_W);
      end else begin
         funct3_legal = (req_funct3 == F3_B)  || (req_funct3 == F3_H)  ||
                        (req_funct3 == F3_W)  || (req_funct3 == F3_BU) ||
                        (req_funct3 == F3_HU);
      end
   end

   // Size is carried in funct3[1:0] for both signed and unsigned forms.
   assign misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                         ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
   assign req_err_next = !funct3_legal || misaligned || out_of_range;
   assign req_is_sw    = req_we && (req_funct3 == F3_W);

   // -------------------------------------------------------------------------
   // Load extraction from the returned word
   // -------------------------------------------------------------------------
   logic [7:0]  load_byte;
   logic [15:0] load_half;
   logic [31:0] load_value;

   always_comb begin
      load_byte = 8'h00;
      case (offset_reg)
         2'd0:    load_byte = mem_rdata[7:0];
         2'd1:    load_byte = mem_rdata[15:8];
         2'd2:    load_byte = mem_rdata[23:16];
         default: load_byte = mem_rdata[31:24];
      endcase
   end

   assign load_half = offset_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];

   always_comb begin
      load_value = mem_rdata;
      case (funct3_reg)
         F3_B:    load_value = {{24{load_byte[7]}}, load_byte};
         F3_H:    load_value = {{16{load_half[15]}}, load_half};
         F3_BU:   load_value = {24'h000000, load_byte};
         F3_HU:   load_value = {16'h0000, load_half};
         default: load_value = mem_rdata;
      endcase
   end

   // -------------------------------------------------------------------------
   // Sub-word store merge: replace the addressed lane(s) of the read word
   // -------------------------------------------------------------------------
   logic [3:0]  lane_en;
   logic [31:0] store_lanes;
   logic [31:0] merged_word;

   // Replicating the store data across all lanes lets every byte pick its
   // new value from the same bit position it occupies in memory.
   assign store_lanes = funct3_reg[0] ? {2{wdata_reg[15:0]}} : {4{wdata_reg[7:0]}};

   always_comb begin
      lane_en = 4'b0000;
      if (funct3_reg[0]) begin
         lane_en = offset_reg[1] ? 4'b1100 : 4'b0011;
      end else begin
         lane_en = 4'b0001 << offset_reg;
      end
   end

   for (genvar gi = 0; gi < 4; gi++) begin : g_merge
      assign merged_word[gi*8 +: 8] = lane_en[gi] ? store_lanes[gi*8 +: 8]
                                                  : mem_rdata[gi*8 +: 8];
   end

   // -------------------------------------------------------------------------
   // Control FSM. Every output is a register updated together with the state
   // it belongs to, so the value is visible for the whole cycle of that state.
   // The asynchronous reset clears mem_we immediately, which is what stops a
   // read-modify-write that is interrupted in its WR cycle.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg  <= IDLE;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_rdata <= 32'h0000_0000;
         resp_err   <= 1'b0;
         mem_addr   <= 32'h0000_0000;
         mem_wdata  <= 32'h0000_0000;
         mem_we     <= 1'b0;
         we_reg     <= 1'b0;
         funct3_reg <= 3'b000;
         offset_reg <= 2'b00;
         wdata_reg  <= 16'h0000;
      end else begin
         case (state_reg)
            IDLE: begin
               resp_valid <= 1'b0;
               resp_err   <= 1'b0;
               mem_we     <= 1'b0;
               if (req_valid) begin
                  req_ready  <= 1'b0;
                  we_reg     <= req_we;
                  funct3_reg <= req_funct3;
                  offset_reg <= req_addr[1:0];
                  wdata_reg  <= req_wdata[15:0];
                  if (req_err_next) begin
                     // Error goes straight to the response; memory untouched.
                     state_reg  <= ERR;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                     resp_rdata <= 32'h0000_0000;
                  end else if (req_is_sw) begin
                     state_reg <= WR;
                     mem_addr  <= word_index;
                     mem_wdata <= req_wdata;
                     mem_we    <= 1'b1;
                  end else begin
                     // Loads and SB/SH both need the current word first.
                     state_reg <= RD;
                     mem_addr  <= word_index;
                  end
               end
            end

            RD: begin
               state_reg <= MRG;
            end

            MRG: begin
               if (we_reg) begin
                  state_reg <= WR;
                  mem_wdata <= merged_word;
                  mem_we    <= 1'b1;
               end else begin
                  state_reg  <= RESP;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b0;
                  resp_rdata <= load_value;
               end
            end

            WR: begin
               state_reg  <= RESP;
               mem_we     <= 1'b0;
               resp_valid <= 1'b1;
               resp_err   <= 1'b0;
               resp_rdata <= 32'h0000_0000;
            end

            RESP, ERR: begin
               state_reg  <= IDLE;
               req_ready  <= 1'b1;
               resp_valid <= 1'b0;
               resp_err   <= 1'b0;
            end

            default: begin
               state_reg  <= IDLE;
               req_ready  <= 1'b1;
               resp_valid <= 1'b0;
               resp_err   <= 1'b0;
               mem_we     <= 1'b0;
            end
         endcase
      end
   end

endmodule
